convertidor_binario_bcd: RTL and testbench
==========================================

CONVERTIDOR_BINARIO_BCD -- requirements
Module: convertidor_binario_bcd

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset.
REQ-002 i_Reloj  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  SHALL be the asynchronous active-low reset (0 = reset asserted).
REQ-004 i_Inicio  input  1  SHALL be the conversion start request, sampled on rising edge.
REQ-005 i_Binario  input  14  SHALL be the unsigned binary value to convert, captured with i_Inicio.
REQ-006 o_Datos_0  output  4  SHALL be the BCD units digit; it connects directly to the display controller's i_Datos_0.
REQ-007 o_Datos_1  output  4  SHALL be the BCD tens digit.
REQ-008 o_Datos_2  output  4  SHALL be the BCD hundreds digit.
REQ-009 o_Datos_3  output  4  SHALL be the BCD thousands digit.
REQ-010 o_Ocupado  output  1  SHALL be high while a conversion is in progress.
REQ-011 o_Listo  output  1  SHALL be a one-cycle pulse marking new digits on o_Datos_0..3.
REQ-012 o_Desborde  output  1  SHALL flag that the last converted input exceeded 9999.

Function
REQ-013 The FSM SHALL have states INACTIVO, DESPLAZA and FIN, with o_Ocupado = (state != INACTIVO).
REQ-014 In INACTIVO with i_Inicio=1 at edge E0, the block SHALL capture i_Binario, clear the BCD scratch register and the iteration counter, and go to DESPLAZA.
REQ-015 In DESPLAZA, each edge E1..E14 SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift left one bit, taking the captured binary MSB first.
REQ-016 The 4-bit iteration counter SHALL move to FIN on E14, after exactly 14 steps.
REQ-017 On E15, in FIN, the block SHALL register the scratch digits onto o_Datos_0..3, drive o_Listo=1 for exactly that cycle, and return to INACTIVO.
REQ-018 Total latency SHALL be fixed at 15 edges from the sampling edge to the o_Listo assertion, independent of the data value.
REQ-019 If the captured value exceeds 9999, FIN SHALL instead drive digits 9,9,9,9 with o_Desborde=1; otherwise o_Desborde=0.
REQ-020 o_Datos_0..3 and o_Desborde SHALL hold their values between conversions so the display stays stable.
REQ-021 i_Inicio asserted in DESPLAZA or FIN SHALL be ignored; it is neither queued nor does it alter the conversion in flight.
REQ-022 i_Inicio held high continuously SHALL start a new conversion on the first edge after returning to INACTIVO, giving back-to-back conversions every 16 edges.
REQ-023 The scratch register and counter SHALL never appear on the outputs; only FIN updates the visible digits.

Reset
REQ-024 Asserting i_Reset=0 SHALL immediately force state INACTIVO, o_Datos_0..3=0, o_Ocupado=0, o_Listo=0, o_Desborde=0, and clear the scratch register and counter.
REQ-025 A reset mid-conversion SHALL abort it with no o_Listo pulse; the first start after reset release SHALL convert normally.

Structure
REQ-026 The shared package SHALL hold the state encoding and the constants ANCHO_BINARIO=14, NUM_DIGITOS=4, MAX_BCD=9999 and ITERACIONES=14.
REQ-027 The per-digit "add 3 if >= 5" correction SHALL be a combinational sub-module, ajuste_bcd, instantiated four times.

Verification
REQ-028 Reset, then start with 1234 -> at E15: o_Datos_3..0 = 1,2,3,4, o_Listo pulse of 1 cycle, o_Desborde=0.
REQ-029 Start with 0, then with 9999 -> digits 0,0,0,0, then 9,9,9,9; o_Desborde=0 both times.
REQ-030 Start with 12000 -> digits 9,9,9,9, o_Desborde=1; a following start with 42 -> 0,0,4,2, o_Desborde=0.
REQ-031 Start with 56, then pulse i_Inicio with 77 at E5 -> only 0,0,5,6 appears; single o_Listo pulse; o_Ocupado low after E15.
REQ-032 Start with 8765, assert i_Reset=0 at E7 -> outputs immediately 0, o_Ocupado=0, no o_Listo; after release, start with 31 -> 0,0,3,1.
REQ-033 i_Inicio held high with inputs 100 then 200 -> o_Listo pulses 16 edges apart, showing 0,1,0,0 then 0,2,0,0.

Source files
------------

// File: rtl/convertidor_binario_bcd_pkg.sv
// Shared constants, FSM state encoding and range helper for the binary-to-BCD converter.
package convertidor_binario_bcd_pkg;

   localparam int ANCHO_BINARIO = 14;
   localparam int NUM_DIGITOS   = 4;
   localparam int MAX_BCD       = 9999;
   localparam int ITERACIONES   = 14;
   localparam int ANCHO_BCD     = 4 * NUM_DIGITOS;

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      DESPLAZA = 2'd1,
      FIN      = 2'd2
   } estado_t;

   // True when the value cannot be shown on four decimal digits.
   function automatic logic excede_max(input logic [ANCHO_BINARIO-1:0] valor);
      return (valor > ANCHO_BINARIO'(MAX_BCD));
   endfunction

endpackage

// File: rtl/convertidor_binario_bcd_ajuste_bcd.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module ajuste_bcd (
   input  logic [3:0] digito,
   output logic [3:0] ajustado
);

   // Conditional +3 so the following left shift carries into the next digit.
   always_comb begin
      ajustado = digito;
      if (digito >= 4'd5) begin
         ajustado = digito + 4'd3;
      end else begin
         ajustado = digito;
      end
   end

endmodule

// File: rtl/convertidor_binario_bcd.sv
// Sequential double-dabble converter: 14-bit binary to four BCD digits with
// fixed 15-edge latency, saturating to 9999 when the input is out of range.
module convertidor_binario_bcd
   import convertidor_binario_bcd_pkg::*;
(
   input  logic                     i_Reloj,
   input  logic                     i_Reset,
   input  logic                     i_Inicio,
   input  logic [ANCHO_BINARIO-1:0] i_Binario,
   output logic [3:0]               o_Datos_0,
   output logic [3:0]               o_Datos_1,
   output logic [3:0]               o_Datos_2,
   output logic [3:0]               o_Datos_3,
   output logic                     o_Ocupado,
   output logic                     o_Listo,
   output logic                     o_Desborde
);

   estado_t                  estado_r;
   logic [ANCHO_BINARIO-1:0] binario_r;
   logic [ANCHO_BCD-1:0]     scratch_r;
   logic [ANCHO_BCD-1:0]     ajustado_s;
   logic [3:0]               contador_r;
   logic                     desborde_pend_r;

   for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
      ajuste_bcd u_ajuste (
         .digito   (scratch_r[4*g +: 4]),
         .ajustado (ajustado_s[4*g +: 4])
      );
   end

   // Conversion FSM; all outputs are registered here.
   always_ff @(posedge i_Reloj or negedge i_Reset) begin
      if (!i_Reset) begin
         estado_r        <= INACTIVO;
         binario_r       <= '0;
         scratch_r       <= '0;
         contador_r      <= 4'd0;
         desborde_pend_r <= 1'b0;
         o_Datos_0       <= 4'd0;
         o_Datos_1       <= 4'd0;
         o_Datos_2       <= 4'd0;
         o_Datos_3       <= 4'd0;
         o_Ocupado       <= 1'b0;
         o_Listo         <= 1'b0;
         o_Desborde      <= 1'b0;
      end else begin
         o_Listo <= 1'b0;
         case (estado_r)
            INACTIVO: begin
               if (i_Inicio) begin
                  binario_r       <= i_Binario;
                  scratch_r       <= '0;
                  contador_r      <= 4'd0;
                  desborde_pend_r <= excede_max(i_Binario);
                  estado_r        <= DESPLAZA;
                  o_Ocupado       <= 1'b1;
               end else begin
                  estado_r  <= INACTIVO;
                  o_Ocupado <= 1'b0;
               end
            end
            DESPLAZA: begin
               scratch_r  <= {ajustado_s[ANCHO_BCD-2:0], binario_r[ANCHO_BINARIO-1]};
               binario_r  <= {binario_r[ANCHO_BINARIO-2:0], 1'b0};
               contador_r <= contador_r + 4'd1;
               if (contador_r == 4'(ITERACIONES - 1)) begin
                  estado_r <= FIN;
               end else begin
                  estado_r <= DESPLAZA;
               end
            end
            FIN: begin
               // Out-of-range inputs saturate rather than show wrapped digits.
               if (desborde_pend_r) begin
                  o_Datos_0 <= 4'd9;
                  o_Datos_1 <= 4'd9;
                  o_Datos_2 <= 4'd9;
                  o_Datos_3 <= 4'd9;
               end else begin
                  o_Datos_0 <= scratch_r[3:0];
                  o_Datos_1 <= scratch_r[7:4];
                  o_Datos_2 <= scratch_r[11:8];
                  o_Datos_3 <= scratch_r[15:12];
               end
               o_Desborde <= desborde_pend_r;
               o_Listo    <= 1'b1;
               o_Ocupado  <= 1'b0;
               estado_r   <= INACTIVO;
            end
            default: begin
               estado_r  <= INACTIVO;
               o_Ocupado <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_convertidor_binario_bcd.sv
// Directed bench for convertidor_binario_bcd with a scoreboard queue of expected results.
module tb_convertidor_binario_bcd;

   logic        i_Reloj;
   logic        i_Reset;
   logic        i_Inicio;
   logic [13:0] i_Binario;
   logic [3:0]  o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3;
   logic        o_Ocupado, o_Listo, o_Desborde;

   typedef struct packed {
      logic [15:0] digitos;
      logic        desborde;
   } esperado_t;

   esperado_t cola[$];
   int checks  = 0;
   int errores = 0;
   logic listo_prev = 1'b0;

   convertidor_binario_bcd dut (
      .i_Reloj    (i_Reloj),
      .i_Reset    (i_Reset),
      .i_Inicio   (i_Inicio),
      .i_Binario  (i_Binario),
      .o_Datos_0  (o_Datos_0),
      .o_Datos_1  (o_Datos_1),
      .o_Datos_2  (o_Datos_2),
      .o_Datos_3  (o_Datos_3),
      .o_Ocupado  (o_Ocupado),
      .o_Listo    (o_Listo),
      .o_Desborde (o_Desborde)
   );

   initial i_Reloj = 1'b0;
   always #5 i_Reloj = ~i_Reloj;

   task automatic chequear(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errores++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic esperado_t modelo(input int v);
      esperado_t e;
      if (v > 9999) begin
         e.digitos  = 16'h9999;
         e.desborde = 1'b1;
      end else begin
         e.digitos  = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
         e.desborde = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard: every o_Listo pulse must match the oldest pending expectation.
   always @(negedge i_Reloj) begin
      if (o_Listo === 1'b1) begin
         chequear("listo_un_ciclo", int'(listo_prev), 0);
         if (cola.size() == 0) begin
            chequear("listo_inesperado", 1, 0);
         end else begin
            esperado_t e;
            e = cola.pop_front();
            chequear("digitos", int'({o_Datos_3, o_Datos_2, o_Datos_1, o_Datos_0}), int'(e.digitos));
            chequear("desborde", int'(o_Desborde), int'(e.desborde));
         end
      end
      listo_prev = o_Listo;
   end

   // Counts negedges until o_Listo, then checks latency and that o_Ocupado dropped.
   task automatic esperar_listo(input int esperado);
      int n = 0;
      bit visto = 0;
      while (n < 40 && !visto) begin
         @(negedge i_Reloj);
         n++;
         if (o_Listo === 1'b1) visto = 1;
      end
      chequear("latencia", visto ? n : -1, esperado);
      chequear("ocupado_tras_fin", int'(o_Ocupado), 0);
   endtask

   // Drives one start pulse (edge E0 follows) and records the expected result.
   task automatic iniciar(input int v);
      @(negedge i_Reloj);
      i_Inicio  = 1'b1;
      i_Binario = 14'(v);
      cola.push_back(modelo(v));
      @(negedge i_Reloj);
      i_Inicio = 1'b0;
      chequear("ocupado_en_curso", int'(o_Ocupado), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      i_Reset   = 1'b0;
      i_Inicio  = 1'b0;
      i_Binario = 14'd0;
      #12;
      chequear("reset_digitos", int'({o_Datos_3, o_Datos_2, o_Datos_1, o_Datos_0}), 0);
      chequear("reset_flags", int'({o_Ocupado, o_Listo, o_Desborde}), 0);
      @(negedge i_Reloj);
      i_Reset = 1'b1;

      iniciar(1234);  esperar_listo(15);
      iniciar(0);     esperar_listo(15);
      iniciar(9999);  esperar_listo(15);
      iniciar(12000); esperar_listo(15);
      iniciar(42);    esperar_listo(15);
      iniciar(16383); esperar_listo(15);

      // Start ignored while busy: pulse 77 around edge E5.
      iniciar(56);
      repeat (4) @(negedge i_Reloj);
      i_Inicio  = 1'b1;
      i_Binario = 14'd77;
      @(negedge i_Reloj);
      i_Inicio = 1'b0;
      esperar_listo(10);
      repeat (3) @(negedge i_Reloj);
      chequear("sin_segundo_listo", int'(o_Ocupado), 0);

      // Reset mid-conversion aborts without a pulse.
      @(negedge i_Reloj);
      i_Inicio  = 1'b1;
      i_Binario = 14'd8765;
      @(negedge i_Reloj);
      i_Inicio = 1'b0;
      repeat (6) @(negedge i_Reloj);
      i_Reset = 1'b0;
      #1;
      chequear("abort_digitos", int'({o_Datos_3, o_Datos_2, o_Datos_1, o_Datos_0}), 0);
      chequear("abort_flags", int'({o_Ocupado, o_Listo, o_Desborde}), 0);
      repeat (20) @(negedge i_Reloj);
      i_Reset = 1'b1;
      iniciar(31); esperar_listo(15);

      // Start held high: back-to-back conversions 16 edges apart.
      @(negedge i_Reloj);
      i_Inicio  = 1'b1;
      i_Binario = 14'd100;
      cola.push_back(modelo(100));
      @(negedge i_Reloj);
      i_Binario = 14'd200;
      cola.push_back(modelo(200));
      esperar_listo(15);
      @(negedge i_Reloj);
      i_Inicio = 1'b0;
      esperar_listo(15);

      repeat (20) @(negedge i_Reloj);
      chequear("cola_vacia", cola.size(), 0);
      chequear("digitos_estables", int'({o_Datos_3, o_Datos_2, o_Datos_1, o_Datos_0}), 16'h0200);

      $display("CHECKS %0d ERRORS %0d", checks, errores);
      $finish;
   end

endmodule
